// File: rtl/adc_frame_pkg.sv
// Shared constants, FSM state type and frame-geometry helpers
// for the ADC frame serializer.
package adc_frame_pkg;

   localparam logic START_BIT = 1'b1;
   localparam logic GUARD_BIT = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GUARD
   } state_e;

   function automatic int ch_id_w(input int num_ch);
      return (num_ch > 2) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int frame_bits(input int id_w, input int data_w,
                                     input bit parity);
      return 1 + id_w + data_w + (parity ? 1 : 0);
   endfunction

endpackage

// File: rtl/adc_frame_serializer_if.sv
// Sample bus and serial line of the ADC frame serializer.
// master = ADC/bench side, slave = serializer side.
interface adc_frame_serializer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic [NUM_CH*DATA_W-1:0] data_in;
   logic [NUM_CH-1:0]        data_valid;
   logic                     clear_overflow;
   logic                     serial_data_out;
   logic                     frame_active;
   logic [NUM_CH-1:0]        overflow;

   modport master (
      output data_in, data_valid, clear_overflow,
      input  serial_data_out, frame_active, overflow
   );

   modport slave (
      input  data_in, data_valid, clear_overflow,
      output serial_data_out, frame_active, overflow
   );
endinterface

// File: rtl/adc_sample_fifo.sv
// Single-clock per-channel sample FIFO; an extra pointer MSB
// separates full from empty.
module adc_sample_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       rptr_q, rptr_d;
   logic              do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
   assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/adc_frame_serializer.sv
// Round-robin serializer of NUM_CH ADC sample FIFOs onto one framed line.
// Define ADC_FRAME_PARITY_EN to append an even-parity bit to each frame.
module adc_frame_serializer
   import adc_frame_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   adc_frame_serializer_if.slave  bus
);
   localparam int CH_ID_W = ch_id_w(NUM_CH);
`ifdef ADC_FRAME_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FB    = frame_bits(CH_ID_W, DATA_W, PAR_EN);
   localparam int BIT_W = $clog2(FB);
   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);

   state_e              state_q, state_d;
   logic [7:0]          div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [FB-1:0]       shift_q, shift_d;
   logic [CH_ID_W-1:0]  ptr_q, ptr_d;
   logic [NUM_CH-1:0]   ovf_q, ovf_d;

   logic [NUM_CH-1:0]   push, pop, full, empty;
   logic [DATA_W-1:0]   rdata [NUM_CH];
   logic                found;
   logic [CH_ID_W-1:0]  sel;
   logic [DATA_W-1:0]   sel_data;
   logic [FB-1:0]       load;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign push[k] = bus.data_valid[k] && !full[k];
      adc_sample_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .push_i  (push[k]),
         .wdata_i (bus.data_in[k*DATA_W +: DATA_W]),
         .pop_i   (pop[k]),
         .rdata_o (rdata[k]),
         .full_o  (full[k]),
         .empty_o (empty[k])
      );
   end

   // A strobe into a full FIFO flags overflow even if it pops this cycle
   assign ovf_d = (bus.data_valid & full) |
                  (bus.clear_overflow ? '0 : ovf_q);
   assign bus.overflow = ovf_q;

   always_comb begin
      int j;
      logic [CH_ID_W-1:0] idx;
      found = 1'b0;
      sel   = '0;
      j     = 0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_CH) j -= NUM_CH;
         idx = CH_ID_W'(j);
         if (!found && !empty[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign sel_data = rdata[sel];
`ifdef ADC_FRAME_PARITY_EN
   assign load = {START_BIT, sel, sel_data, ^{sel, sel_data}};
`else
   assign load = {START_BIT, sel, sel_data};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ptr_q   <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = SHIFT;
               shift_d = load;
               div_d   = '0;
               bit_d   = '0;
               ptr_d   = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               shift_d = {shift_q[FB-2:0], 1'b0};
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = GUARD;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GUARD: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.serial_data_out = GUARD_BIT;
      bus.frame_active    = 1'b0;
      pop                 = '0;
      unique case (state_q)
         IDLE: begin
            if (found) pop = NUM_CH'(1) << sel;
         end
         SHIFT: begin
            bus.serial_data_out = shift_q[FB-1];
            bus.frame_active    = 1'b1;
         end
         GUARD: begin
            bus.serial_data_out = GUARD_BIT;
            bus.frame_active    = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_adc_frame_serializer.sv
// Directed bench: dut_a (CLK_DIV=1) and dut_b (CLK_DIV=3), NUM_CH=4.
module tb_adc_frame_serializer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

`ifdef ADC_FRAME_PARITY_EN
   localparam int FB = 20;
   localparam logic [31:0] EXP_A5C3 = 32'h0009_4B86;
   localparam logic [31:0] EXP_B    = 32'h000A_000E;
`else
   localparam int FB = 19;
   localparam logic [31:0] EXP_A5C3 = 32'h0004_A5C3;
   localparam logic [31:0] EXP_B    = 32'h0005_0007;
`endif

   adc_frame_serializer_if #(.NUM_CH(4), .DATA_W(16)) ifa ();
   adc_frame_serializer_if #(.NUM_CH(4), .DATA_W(16)) ifb ();

   adc_frame_serializer #(
      .NUM_CH(4), .DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(1)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   adc_frame_serializer #(
      .NUM_CH(4), .DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(3)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic fa(input int w);
      return (w == 0) ? ifa.frame_active : ifb.frame_active;
   endfunction

   function automatic logic ln(input int w);
      return (w == 0) ? ifa.serial_data_out : ifb.serial_data_out;
   endfunction

   function automatic logic [31:0] frm(input logic [1:0] id,
                                      input logic [15:0] d);
`ifdef ADC_FRAME_PARITY_EN
      return {12'b0, 1'b1, id, d, ^{id, d}};
`else
      return {13'b0, 1'b1, id, d};
`endif
   endfunction

   task automatic strobe(input int w, input logic [3:0] m,
                         input logic [63:0] d);
      @(posedge clk); #1;
      if (w == 0) begin
         ifa.data_valid = m;
         ifa.data_in    = d;
      end else begin
         ifb.data_valid = m;
         ifb.data_in    = d;
      end
      @(posedge clk); #1;
      ifa.data_valid = '0;
      ifb.data_valid = '0;
   endtask

   // Sample each bit on every cycle it is held; first cycle records it
   task automatic get_frame(input int w, input int div,
                            output logic [31:0] got, output int act,
                            output int lat, output logic held);
      got  = '0;
      act  = 0;
      lat  = 0;
      held = 1'b1;
      @(negedge clk);
      while (fa(w) !== 1'b1 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < FB; i++) begin
         for (int d = 0; d < div; d++) begin
            if (d == 0) got = {got[30:0], ln(w)};
            else if (ln(w) !== got[0]) held = 1'b0;
            if (fa(w) === 1'b1) act++;
            @(negedge clk);
         end
      end
      for (int d = 0; d < div; d++) begin
         if (ln(w) !== 1'b0) held = 1'b0;
         if (fa(w) === 1'b1) act++;
         @(negedge clk);
      end
      while (fa(w) === 1'b1 && act < 1000) begin
         act++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] got;
      int          act, lat, cnt;
      logic        held;
      logic [15:0] d2;

      ifa.data_in = '0; ifa.data_valid = '0; ifa.clear_overflow = 1'b0;
      ifb.data_in = '0; ifb.data_valid = '0; ifb.clear_overflow = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_line", 32'(ln(0)), 32'd0);
      chk("rst_active", 32'(fa(0)), 32'd0);
      chk("rst_ovf", 32'(ifa.overflow), 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      strobe(0, 4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      for (int k = 0; k < 4; k++) begin
         get_frame(0, 1, got, act, lat, held);
         chk($sformatf("all4_ch%0d_bits", k), got,
             frm(2'(k), 16'(k + 1)));
         chk($sformatf("all4_ch%0d_act", k), 32'(act), 32'(FB + 1));
      end
      chk("all4_ovf", 32'(ifa.overflow), 32'd0);

      strobe(0, 4'b0001, {48'h0, 16'hA5C3});
      get_frame(0, 1, got, act, lat, held);
      chk("single_lat", 32'(lat), 32'd1);
      chk("single_bits", got, EXP_A5C3);
      chk("single_act", 32'(act), 32'(FB + 1));
      chk("single_held", 32'(held), 32'd1);

      strobe(0, 4'b0100, {16'h0, 16'h2BAD, 32'h0});
      get_frame(0, 1, got, act, lat, held);
      chk("rr_ch2", got, frm(2'd2, 16'h2BAD));
      strobe(0, 4'b1001, {16'hD003, 32'h0, 16'hD000});
      get_frame(0, 1, got, act, lat, held);
      chk("rr_first_ch3", got, frm(2'd3, 16'hD003));
      get_frame(0, 1, got, act, lat, held);
      chk("rr_then_ch0", got, frm(2'd0, 16'hD000));

      fork
         get_frame(0, 1, got, act, lat, held);
         begin
            @(posedge clk); #1;
            ifa.data_valid = 4'b0001;
            ifa.data_in    = {48'h0, 16'h0A0A};
            d2 = 16'h0000;
            for (int i = 0; i < 5; i++) begin
               @(posedge clk); #1;
               d2 = d2 + 16'h1111;
               ifa.data_valid = 4'b0100;
               ifa.data_in    = {16'h0, d2, 32'h0};
            end
            @(posedge clk); #1;
            ifa.data_valid = '0;
         end
      join
      chk("ovf_ch0_frame", got, frm(2'd0, 16'h0A0A));
      chk("ovf_set", 32'(ifa.overflow), 32'h4);
      d2 = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         d2 = d2 + 16'h1111;
         get_frame(0, 1, got, act, lat, held);
         chk($sformatf("ovf_ch2_frame%0d", i), got, frm(2'd2, d2));
      end
      @(negedge clk);
      chk("ovf_no_fifth", 32'(fa(0)), 32'd0);
      chk("ovf_sticky", 32'(ifa.overflow), 32'h4);
      @(posedge clk); #1 ifa.clear_overflow = 1'b1;
      @(posedge clk); #1 ifa.clear_overflow = 1'b0;
      @(negedge clk);
      chk("ovf_clear", 32'(ifa.overflow), 32'd0);

      strobe(0, 4'b0111, {16'h0, 16'h2222, 16'h1111, 16'h0F0F});
      cnt = 0;
      while (fa(0) !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("mid_started", 32'(fa(0)), 32'd1);
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_line", 32'(ln(0)), 32'd0);
      chk("mid_rst_active", 32'(fa(0)), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (fa(0) !== 1'b0) cnt++;
      end
      chk("post_rst_quiet", 32'(cnt), 32'd0);
      strobe(0, 4'b1000, {16'hBEEF, 48'h0});
      get_frame(0, 1, got, act, lat, held);
      chk("post_rst_frame", got, frm(2'd3, 16'hBEEF));

      strobe(1, 4'b0010, {32'h0, 16'h0007, 16'h0});
      get_frame(1, 3, got, act, lat, held);
      chk("div3_lat", 32'(lat), 32'd1);
      chk("div3_bits", got, EXP_B);
      chk("div3_act", 32'(act), 32'((FB + 1) * 3));
      chk("div3_held", 32'(held), 32'd1);
      chk("div3_ovf", 32'(ifb.overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_frame_serializer.md
Name: adc_frame_serializer

Overview:
- Parametrised successor to the two-channel ADC data serializer.
- Accepts conversion results from NUM_CH ADC controllers and buffers each channel in its own FIFO.
- Arbitrates between channels round-robin.
- Emits each sample as a framed, channel-tagged serial word on one output line to the master FPGA.

Parameters:
- NUM_CH, 4: number of ADC channels (2..16).
- DATA_W, 16: sample width in bits.
- FIFO_DEPTH, 4: samples buffered per channel; must be a power of 2, at least 2.
- CLK_DIV, 1: clk cycles per serial bit (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  NUM_CH*DATA_W  flattened samples; channel k occupies bits [k*DATA_W +: DATA_W].
- data_valid  in  NUM_CH  per-channel one-cycle strobe; data for channel k is sampled when bit k is high.
- clear_overflow  in  1  one-cycle pulse that clears all overflow flags.
- serial_data_out  out  1  framed serial stream; idles low.
- frame_active  out  1  high while a frame or its guard bit is on the line.
- overflow  out  NUM_CH  sticky per-channel sample-dropped flags.

Behaviour:
- Reset (reset=0, asynchronous): serial_data_out=0, frame_active=0, overflow=0.
  - All FIFOs are emptied.
  - Round-robin pointer is set to 0.
  - Divider and bit counters are set to 0. FSM goes to IDLE.
  - Reset asserted mid-frame truncates the frame immediately; the line goes low.
- CH_ID_W = max(1, clog2(NUM_CH)).
- Frame layout, MSB first: start bit 1, channel ID (CH_ID_W bits), data (DATA_W bits), then one guard bit 0.
  - FRAME_BITS = 1 + CH_ID_W + DATA_W (+1 with parity).
- FIFO write:
  - data_valid[k]=1 and FIFO k not full: sample is pushed.
  - data_valid[k]=1 and FIFO k full: sample is dropped and overflow[k] is set, even if a pop of FIFO k happens in the same cycle.
  - Set and clear in the same cycle: set wins.
  - clear_overflow otherwise zeroes every flag.
- FSM states:
  - IDLE: if any FIFO is non-empty, select the first non-empty channel at or after the pointer, cyclically. Pop it, load the shift register {1, id, data}, and set the pointer to (selected+1) mod NUM_CH. Go to SHIFT. frame_active rises on the same edge.
  - SHIFT: each bit is held for exactly CLK_DIV cycles. After FRAME_BITS bits, go to GUARD.
  - GUARD: line held at 0 for CLK_DIV cycles, then return to IDLE. frame_active falls on the exit edge.
- Latency: a sample strobed on edge t into an empty system puts its start bit on the line from edge t+2. Each frame occupies (FRAME_BITS+1)*CLK_DIV cycles.
- The next frame may start on the edge that leaves GUARD, if IDLE sees data that cycle. IDLE therefore lasts at least 1 cycle between frames.
- A push to a FIFO that is empty while the FSM is in SHIFT waits; no preemption.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.

Optional Feature:
- Macro: ADC_FRAME_PARITY_EN.
- When defined: an even-parity bit over the channel ID and data bits is appended after data LSB and before the guard bit; FRAME_BITS increases by 1.
- When undefined: no parity bit; layout as above.

Decomposition:
- Shared package adc_frame_pkg holds:
  - START_BIT=1 and GUARD_BIT=0 constants;
  - the CH_ID_W computation function;
  - the FSM state typedef (IDLE, SHIFT, GUARD);
  - the frame-length function taking the parity option.
- One natural sub-module: adc_sample_fifo, a synchronous single-clock FIFO (DATA_W, FIFO_DEPTH; push/pop/full/empty), instantiated NUM_CH times.

Test Plan:
- Single sample, NUM_CH=4, CLK_DIV=1: data_valid[0] with 0xA5C3 -> line shows 1,00,1010010111000011 then 0; frame_active high for 20 cycles.
- All four data_valid strobes in the same cycle, values 0x0001..0x0004 -> frames appear in channel order 0,1,2,3 with IDs 00,01,10,11; no overflow.
- Arbitration fairness: after channel 2 is served, strobe channels 0 and 3 together -> channel 3 is sent first, then channel 0.
- Overflow: five strobes on channel 2 while a channel-0 frame is in flight, FIFO_DEPTH=4 -> fifth sample dropped and overflow[2]=1; four channel-2 frames follow; a clear_overflow pulse returns overflow[2] to 0.
- CLK_DIV=3, ADC_FRAME_PARITY_EN defined, channel 1 data 0x0007 -> each bit held 3 cycles; parity bit = 0 (ID and data together contain four 1s); frame_active lasts 63 cycles.
- Reset asserted at bit 8 of a frame with two samples queued -> serial_data_out=0 and frame_active=0 immediately; after release, no frame is emitted until a new strobe arrives.
